timer_regs: RTL and testbench
=============================

# timer_regs

Memory-mapped machine-timer and software-interrupt register file. It sits directly downstream of the AXI-Lite slave interface and consumes its memory-like request port (enable, write-enable, address, write data). It returns read data one cycle after a read request. It keeps a free-running `mtime` counter, advanced by a real-time-clock tick, and drives per-hart timer and software interrupt lines.

## Interface
- `AXI_ADDR_WIDTH`, default 64: request address width.
- `AXI_DATA_WIDTH`, default 64: data width. Only 64 is supported.
- `NR_CORES`, default 1: number of harts, range 1..64.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, 1: request valid for this cycle.
- `we_i`, in, 1: 1 = write, 0 = read. Qualified by `en_i`.
- `address_i`, in, AXI_ADDR_WIDTH: byte address. Bits [15:3] are decoded; all other bits are ignored.
- `wdata_i`, in, AXI_DATA_WIDTH: write data.
- `rdata_o`, out, AXI_DATA_WIDTH: read data, registered.
- `rtc_i`, in, 1: real-time-clock level, already synchronised to `clk_i`.
- `timer_irq_o`, out, NR_CORES: machine timer interrupt, one bit per hart.
- `ipi_o`, out, NR_CORES: machine software interrupt, one bit per hart.

## Operation
Register map (offset = `address_i[15:0]` with bits [2:0] cleared):
- `0x0000 + 8*i`: `msip[i]`. Only bit 0 is storage. Writes update bit 0 only. Reads return `{63'b0, msip[i]}`.
- `0x4000 + 8*i`: `mtimecmp[i]`, 64 bits, read/write.
- `0xBFF8`: `mtime`, 64 bits, read/write.
- Index `i` must be less than NR_CORES. Any other offset is unmapped: reads return 0 and writes are dropped, with no error.

Access rules:
- Only full 64-bit accesses. There are no byte strobes.
- A write updates the target register on the clock edge ending the request cycle.
- A read captures the target value into `rdata_o` on the same edge.
- `rdata_o` holds its value until the next read request. Writes and idle cycles never change it. This lets the upstream interface hold `r_valid` across several stall cycles.

RTC tick:
- A rising edge on `rtc_i` is detected with one register `rtc_q`: tick = `rtc_i & ~rtc_q`.
- On a tick, `mtime <= mtime + 1`. The counter wraps modulo 2^64: `0xFFFF_FFFF_FFFF_FFFF` goes to 0.
- Simultaneous tick and `mtime` write: the write wins, and the tick is lost.

Interrupts:
- `timer_irq_o[i]` is a register, loaded each cycle with `mtime >= mtimecmp[i]` (64-bit unsigned compare) using the current register values.
- `ipi_o[i]` is the `msip[i]` register driven directly.

Read of a register written in the same cycle: `rdata_o` captures the old value. A read and a write cannot coincide, because `we_i` selects one operation.

## Timing
Reset values (applied on any clock edge with `rst_i = 1`, including mid-operation, when all state is discarded):
- `mtime = 0`
- `mtimecmp[*] = 0xFFFF_FFFF_FFFF_FFFF`
- `msip[*] = 0`
- `rtc_q = 0`
- `rdata_o = 0`
- `timer_irq_o = 0`
- `ipi_o = 0`

Latencies:
- Read: request in cycle N, data on `rdata_o` in cycle N+1.
- Write: the new value is visible to a read issued in cycle N+1.
- `ipi_o`: changes in cycle N+1 after a write in cycle N.
- `timer_irq_o`: reflects register state one cycle late. A compare-relevant update in cycle N (tick or write) shows on `timer_irq_o` in cycle N+2.
- `rtc_i` rising in cycle N: `mtime` increments at the end of cycle N. `rtc_i` held high for many cycles gives exactly one increment.

There is no back-pressure: a request is accepted every cycle `en_i = 1`.

## Test plan
1. Reset, then read `0xBFF8`, `0x4000`, `0x0000`. Required: `rdata_o` = 0, `0xFFFF_FFFF_FFFF_FFFF`, 0 respectively. `timer_irq_o = 0` and `ipi_o = 0` throughout.
2. Toggle `rtc_i` 5 times, each high phase lasting 3 cycles, then read `mtime`. Required: `rdata_o = 5`.
3. Write `mtimecmp[0] = 3` with `mtime = 0`, then give 3 RTC edges. Required: `timer_irq_o[0]` rises exactly 2 cycles after the third tick. Then write `mtimecmp[0] = 100`. Required: the irq drops 2 cycles after the write.
4. Write `mtime = 0xFFFF_FFFF_FFFF_FFFF`, give one tick, then read. Required: `rdata_o = 0`. Also write `mtime = 7` in the same cycle as a tick. Required: a read returns 7.
5. Write `0xFFFF_FFFF_FFFF_FFFF` to `msip[0]`. Required: `ipi_o[0] = 1` next cycle, and a read returns 1. Write 0. Required: `ipi_o[0] = 0`.
6. With NR_CORES = 1: write to `0x0008` and `0x4008`, then read both. Required: both reads return 0 and no other register changes. Then read `mtime`, followed by 3 idle cycles and one write. Required: `rdata_o` stays at the `mtime` value throughout. Finally, assert `rst_i` mid-sequence. Required: all reset values return on the next edge.

Source files
------------

// File: rtl/timer_regs.sv
// timer_regs: machine-timer / software-interrupt register file with free-running mtime.
module timer_regs #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int NR_CORES       = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] address_i,
  input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
  output logic [AXI_DATA_WIDTH-1:0] rdata_o,
  input  logic                      rtc_i,
  output logic [NR_CORES-1:0]       timer_irq_o,
  output logic [NR_CORES-1:0]       ipi_o
);
  localparam int DW = AXI_DATA_WIDTH;
  logic [DW-1:0] r_mtime, r_rdata, w_rdata;
  logic [DW-1:0] r_mtimecmp [NR_CORES];
  logic [NR_CORES-1:0] r_msip, r_timer_irq;
  logic r_rtc_q, w_tick, w_wr, w_wr_mtime, w_unused;
  logic [12:0] w_word, w_cmp_word;
  assign w_word     = address_i[15:3];
  // mtimecmp lives at word 0x800; offsets below it wrap far above NR_CORES
  assign w_cmp_word = w_word - 13'h0800;
  assign w_wr       = en_i & we_i;
  assign w_wr_mtime = w_wr & (w_word == 13'h17FF);
  assign w_tick     = rtc_i & ~r_rtc_q;
  assign w_unused   = ^{address_i[AXI_ADDR_WIDTH-1:16], address_i[2:0]};
  assign rdata_o     = r_rdata;
  assign timer_irq_o = r_timer_irq;
  assign ipi_o       = r_msip;
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NR_CORES; i++) begin
      if (w_word == 13'(i)) w_rdata = {{(DW-1){1'b0}}, r_msip[i]};
      if (w_cmp_word == 13'(i)) w_rdata = r_mtimecmp[i];
    end
    if (w_word == 13'h17FF) w_rdata = r_mtime;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mtime     <= '0;
      r_msip      <= '0;
      r_rtc_q     <= 1'b0;
      r_rdata     <= '0;
      r_timer_irq <= '0;
      for (int i = 0; i < NR_CORES; i++) r_mtimecmp[i] <= '1;
    end else begin
      r_rtc_q <= rtc_i;
      r_mtime <= w_wr_mtime ? wdata_i : r_mtime + DW'(w_tick);
      if (en_i && !we_i) r_rdata <= w_rdata;
      for (int i = 0; i < NR_CORES; i++) begin
        if (w_wr && w_word == 13'(i)) r_msip[i] <= wdata_i[0];
        if (w_wr && w_cmp_word == 13'(i)) r_mtimecmp[i] <= wdata_i;
        r_timer_irq[i] <= r_mtime >= r_mtimecmp[i];
      end
    end
  end
endmodule

// File: tb/tb_timer_regs.sv
// tb_timer_regs: directed, self-checking bench for timer_regs (NR_CORES = 1).
module tb_timer_regs;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic        we_i = 1'b0;
  logic [63:0] address_i = '0;
  logic [63:0] wdata_i = '0;
  logic [63:0] rdata_o;
  logic        rtc_i = 1'b0;
  logic [0:0]  timer_irq_o;
  logic [0:0]  ipi_o;
  int n_tests = 0;
  int n_fail = 0;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  timer_regs #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .NR_CORES(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .we_i(we_i), .address_i(address_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rtc_i(rtc_i), .timer_irq_o(timer_irq_o), .ipi_o(ipi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    en_i = 1'b1; we_i = 1'b1; address_i = a; wdata_i = d;
    cyc();
    en_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a);
    en_i = 1'b1; we_i = 1'b0; address_i = a;
    cyc();
    en_i = 1'b0;
  endtask

  task automatic tick();
    rtc_i = 1'b1; cyc();
    rtc_i = 1'b0; cyc();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cyc(2); rst_i = 1'b0;
    n_tests++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    rd(64'hBFF8);
    n_tests++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL reset_mtime: got %h want 0", rdata_o); end
    rd(64'h4000);
    n_tests++; if (rdata_o !== ALL1) begin n_fail++; $display("FAIL reset_mtimecmp: got %h want %h", rdata_o, ALL1); end
    rd(64'h0000);
    n_tests++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL reset_msip: got %h want 0", rdata_o); end
    n_tests++; if (timer_irq_o !== 1'b0 || ipi_o !== 1'b0) begin n_fail++; $display("FAIL reset_irqs: got irq=%b ipi=%b want 0 0", timer_irq_o, ipi_o); end
  endtask

  task automatic test_rtc_count();
    for (int k = 0; k < 5; k++) begin
      rtc_i = 1'b1; cyc(3);
      rtc_i = 1'b0; cyc(2);
    end
    rd(64'hBFF8);
    n_tests++; if (rdata_o !== 64'd5) begin n_fail++; $display("FAIL rtc_count: got %h want 5", rdata_o); end
    n_tests++; if (timer_irq_o !== 1'b0) begin n_fail++; $display("FAIL rtc_no_irq: got %b want 0", timer_irq_o); end
  endtask

  task automatic test_timer_irq();
    wr(64'hBFF8, 64'd0);
    wr(64'h4000, 64'd3);
    tick(); tick();
    n_tests++; if (timer_irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_before_cmp: got %b want 0", timer_irq_o); end
    rtc_i = 1'b1; cyc(); rtc_i = 1'b0;
    n_tests++; if (timer_irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_tick_plus1: got %b want 0", timer_irq_o); end
    cyc();
    n_tests++; if (timer_irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_tick_plus2: got %b want 1", timer_irq_o); end
    wr(64'h4000, 64'd100);
    n_tests++; if (timer_irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_hold_after_write: got %b want 1", timer_irq_o); end
    cyc();
    n_tests++; if (timer_irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b want 0", timer_irq_o); end
  endtask

  task automatic test_mtime_wrap();
    wr(64'hBFF8, ALL1);
    tick();
    rd(64'hBFF8);
    n_tests++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL mtime_wrap: got %h want 0", rdata_o); end
    rtc_i = 1'b1;
    wr(64'hBFF8, 64'd7);
    rtc_i = 1'b0;
    rd(64'hBFF8);
    n_tests++; if (rdata_o !== 64'd7) begin n_fail++; $display("FAIL write_beats_tick: got %h want 7", rdata_o); end
  endtask

  task automatic test_msip();
    wr(64'h0000, ALL1);
    n_tests++; if (ipi_o !== 1'b1) begin n_fail++; $display("FAIL ipi_set: got %b want 1", ipi_o); end
    rd(64'h0000);
    n_tests++; if (rdata_o !== 64'd1) begin n_fail++; $display("FAIL msip_read: got %h want 1", rdata_o); end
    wr(64'h0000, 64'hFFFF_FFFF_FFFF_FFFE);
    n_tests++; if (ipi_o !== 1'b0) begin n_fail++; $display("FAIL ipi_bit0_only: got %b want 0", ipi_o); end
    wr(64'h0000, ALL1);
    wr(64'h0000, 64'd0);
    n_tests++; if (ipi_o !== 1'b0) begin n_fail++; $display("FAIL ipi_clear: got %b want 0", ipi_o); end
  endtask

  task automatic test_unmapped_and_hold();
    wr(64'h0008, 64'h55);
    wr(64'h4008, 64'h66);
    rd(64'h0008);
    n_tests++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL unmapped_msip1: got %h want 0", rdata_o); end
    rd(64'h4008);
    n_tests++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL unmapped_cmp1: got %h want 0", rdata_o); end
    rd(64'h0000);
    n_tests++; if (rdata_o !== 64'd0 || ipi_o !== 1'b0) begin n_fail++; $display("FAIL msip0_untouched: got %h ipi=%b want 0 0", rdata_o, ipi_o); end
    rd(64'h4000);
    n_tests++; if (rdata_o !== 64'd100) begin n_fail++; $display("FAIL cmp0_untouched: got %h want 100", rdata_o); end
    rd(64'h1_0000_BFFF);
    n_tests++; if (rdata_o !== 64'd7) begin n_fail++; $display("FAIL ignored_addr_bits: got %h want 7", rdata_o); end
    rd(64'h4000);
    rd(64'hBFF8);
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_tests++; if (rdata_o !== 64'd7) begin n_fail++; $display("FAIL rdata_hold_idle%0d: got %h want 7", k, rdata_o); end
    end
    wr(64'h4000, 64'd0);
    n_tests++; if (rdata_o !== 64'd7) begin n_fail++; $display("FAIL rdata_hold_write: got %h want 7", rdata_o); end
    wr(64'h0000, 64'd1);
    cyc();
    n_tests++; if (timer_irq_o !== 1'b1 || ipi_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irqs: got irq=%b ipi=%b want 1 1", timer_irq_o, ipi_o); end
    rst_i = 1'b1; en_i = 1'b1; we_i = 1'b1; address_i = 64'hBFF8; wdata_i = 64'd99;
    cyc();
    rst_i = 1'b0; en_i = 1'b0; we_i = 1'b0;
    n_tests++; if (rdata_o !== 64'd0 || timer_irq_o !== 1'b0 || ipi_o !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_outs: got rdata=%h irq=%b ipi=%b want 0 0 0", rdata_o, timer_irq_o, ipi_o); end
    rd(64'hBFF8);
    n_tests++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL midrun_reset_mtime: got %h want 0", rdata_o); end
    rd(64'h4000);
    n_tests++; if (rdata_o !== ALL1) begin n_fail++; $display("FAIL midrun_reset_cmp: got %h want %h", rdata_o, ALL1); end
  endtask

  initial begin
    test_reset();
    test_rtc_count();
    test_timer_irq();
    test_mtime_wrap();
    test_msip();
    test_unmapped_and_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
